// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
// Package   : csa_pkg
// Purpose   : Shared types and the element-boundary mask for csa_accum.
// Revision  : 1.0
// ============================================================================
package csa_pkg;

    localparam int MAX_WIDTH = 1024;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic [1:0] {
        ACC     = 2'b00,
        RESOLVE = 2'b01,
        HOLD    = 2'b10
    } state_e;

    // The reserved encoding 2'b11 behaves as 32-bit elements.
    function automatic sew_e decode_sew(input logic [1:0] raw);
        case (raw)
            2'b00:   return SEW8;
            2'b01:   return SEW16;
            default: return SEW32;
        endcase
    endfunction

    function automatic logic [MAX_WIDTH-1:0] boundary_mask(input int width, input sew_e sew);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        case (sew)
            SEW8: begin
                for (int i = 0; i < MAX_WIDTH; i += 8)
                    if (i < width) m[i] = 1'b1;
            end
            SEW16: begin
                for (int i = 0; i < MAX_WIDTH; i += 16)
                    if (i < width) m[i] = 1'b1;
            end
            default: begin
                for (int i = 0; i < MAX_WIDTH; i += 32)
                    if (i < width) m[i] = 1'b1;
            end
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_row.sv
`default_nettype none
// ============================================================================
// Module    : csa_row
// Purpose   : One 3:2 carry-save level with carries killed at element starts.
// Revision  : 1.0
// ============================================================================
module csa_row #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] kill_mask,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] w_maj;

    assign sum   = a ^ b ^ c;
    assign w_maj = (a & b) | (a & c) | (b & c);
    assign carry = (w_maj << 1) & ~kill_mask;

endmodule
`default_nettype wire

// File: rtl/csa_accum.sv
`default_nettype none
// ============================================================================
// Module    : csa_accum
// Purpose   : Per-element carry-save packet accumulator with segmented resolve.
// Revision  : 1.0
// ============================================================================
module csa_accum
    import csa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sew,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int NSLICE = WIDTH / 8;

    state_e           state;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] carry_r;
    logic [CNT_W-1:0] cnt;
    logic             first;
    sew_e             sew_r;

    sew_e             w_sew_eff;
    logic [WIDTH-1:0] w_kill;
    logic [WIDTH-1:0] w_row_sum;
    logic [WIDTH-1:0] w_row_carry;
    logic [WIDTH-1:0] w_cpa;
    logic [NSLICE-2:0] w_co;
    logic             w_accept;

    assign in_ready  = (state == ACC);
    assign w_accept  = in_valid && in_ready;
    assign w_sew_eff = first ? decode_sew(sew) : sew_r;
    assign w_kill    = WIDTH'(boundary_mask(WIDTH, w_sew_eff));

    csa_row #(.WIDTH(WIDTH)) u_row (
        .a         (sum_r),
        .b         (carry_r),
        .c         (in_data),
        .kill_mask (w_kill),
        .sum       (w_row_sum),
        .carry     (w_row_carry)
    );

    // Byte slices; the carry into a slice is gated off where an element starts.
    for (genvar j = 0; j < NSLICE; j++) begin : g_slice
        logic w_ci;
        if (j == 0) begin : g_first
            assign w_ci = 1'b0;
        end else begin : g_chain
            logic w_cut;
            assign w_cut = (sew_r == SEW8) || ((sew_r == SEW16) && ((j % 2) == 0)) || ((j % 4) == 0);
            assign w_ci  = w_co[j-1] & ~w_cut;
        end
        if (j == NSLICE - 1) begin : g_top
            assign w_cpa[8*j +: 8] = sum_r[8*j +: 8] + carry_r[8*j +: 8] + {7'b0, w_ci};
        end else begin : g_mid
            assign {w_co[j], w_cpa[8*j +: 8]} = {1'b0, sum_r[8*j +: 8]} + {1'b0, carry_r[8*j +: 8]} + {8'b0, w_ci};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            sum_r     <= '0;
            carry_r   <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
            first     <= 1'b1;
            sew_r     <= SEW32;
        end else begin
            case (state)
                ACC: begin
                    if (w_accept) begin
                        sum_r   <= w_row_sum;
                        carry_r <= w_row_carry;
                        if (first) begin
                            sew_r <= w_sew_eff;
                            first <= 1'b0;
                        end
                        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                        if (in_last) state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    out_data  <= w_cpa;
                    out_count <= cnt;
                    out_valid <= 1'b1;
                    sum_r     <= '0;
                    carry_r   <= '0;
                    cnt       <= '0;
                    first     <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_accum.sv
`default_nettype none
// ============================================================================
// Module    : tb_csa_accum
// Purpose   : Self-checking bench for csa_accum against a per-element sum model.
// Revision  : 1.0
// ============================================================================
module tb_csa_accum;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       sew;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sew       (sew),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    // Model: 0 = taking beats, 1 = resolving, 2 = result presented
    int               phase;
    logic [WIDTH-1:0] beats[$];
    int               pkt_esz;
    int               pkt_len;
    logic [WIDTH-1:0] exp_data;
    logic [CNT_W-1:0] exp_count;
    bit               auto_ready;

    function automatic int esz_of(input logic [1:0] s);
        if (s == 2'b00) return 8;
        if (s == 2'b01) return 16;
        return 32;
    endfunction

    function automatic logic [WIDTH-1:0] seg_sum(input int esz);
        logic [63:0] r;
        logic [63:0] acc;
        logic [63:0] emask;
        r = '0;
        emask = (64'd1 << esz) - 64'd1;
        for (int e = 0; e < WIDTH / esz; e++) begin
            acc = '0;
            foreach (beats[k]) acc += (64'(beats[k]) >> (e * esz)) & emask;
            r |= (acc & emask) << (e * esz);
        end
        return r[WIDTH-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit acc;
        bit hs;
        if (auto_ready) out_ready = ($urandom_range(0, 2) != 0);
        acc = in_valid && (phase == 0);
        hs  = (phase == 2) && out_ready;
        @(posedge clk);
        @(negedge clk);
        case (phase)
            0: if (acc) begin
                if (beats.size() == 0) begin
                    pkt_esz = esz_of(sew);
                    pkt_len = 0;
                end
                beats.push_back(in_data);
                pkt_len++;
                if (in_last) phase = 1;
            end
            1: begin
                exp_data  = seg_sum(pkt_esz);
                exp_count = (pkt_len >= (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(pkt_len);
                beats.delete();
                phase = 2;
            end
            default: if (hs) phase = 0;
        endcase
        check("in_ready", 64'(in_ready), 64'(phase == 0));
        check("out_valid", 64'(out_valid), 64'(phase == 2));
        if (phase == 2) begin
            check("out_data", 64'(out_data), 64'(exp_data));
            check("out_count", 64'(out_count), 64'(exp_count));
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input bit last, input logic [1:0] s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        sew      = s;
        while (phase != 0 && n < 100) begin
            cycle();
            n++;
        end
        if (phase != 0) check("send_timeout", 64'(phase), 64'd0);
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic expect_result(input logic [WIDTH-1:0] d, input logic [63:0] c);
        int n;
        n = 0;
        while (phase != 2 && n < 10) begin
            cycle();
            n++;
        end
        check("pkt_data", 64'(out_data), 64'(d));
        check("pkt_count", 64'(out_count), c);
        check("model_data", 64'(exp_data), 64'(d));
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        phase = 0;
        beats.delete();
        exp_data  = '0;
        exp_count = '0;
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        sew        = 2'b10;
        out_ready  = 1'b1;
        auto_ready = 1'b0;
        phase      = 0;
        exp_data   = '0;
        exp_count  = '0;
        @(negedge clk);
        do_reset();

        send(32'd1, 1'b0, 2'b10);
        send(32'd2, 1'b0, 2'b10);
        send(32'd3, 1'b1, 2'b10);
        expect_result(32'h00000006, 64'd3);

        send(32'hFF01FF80, 1'b0, 2'b00);
        send(32'h01FF0180, 1'b1, 2'b00);
        expect_result(32'h00000000, 64'd2);

        send(32'h0001FFFF, 1'b0, 2'b01);
        send(32'h00000001, 1'b1, 2'b01);
        expect_result(32'h00010000, 64'd2);

        send(32'h000000FF, 1'b0, 2'b00);
        send(32'h00000001, 1'b0, 2'b10);
        send(32'h00000001, 1'b1, 2'b10);
        expect_result(32'h00000001, 64'd3);

        // Result held under backpressure while the source keeps offering beats
        out_ready = 1'b0;
        send(32'h12345678, 1'b1, 2'b10);
        cycle();
        cycle();
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'hDEADBEEF;
        repeat (5) cycle();
        check("bp_data", 64'(out_data), 64'h12345678);
        check("bp_count", 64'(out_count), 64'd1);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

        send(32'h10, 1'b0, 2'b10);
        send(32'h20, 1'b0, 2'b10);
        do_reset();
        send(32'h7, 1'b1, 2'b10);
        expect_result(32'h00000007, 64'd1);

        out_ready = 1'b0;
        send(32'h5, 1'b1, 2'b10);
        cycle();
        cycle();
        do_reset();
        out_ready = 1'b1;

        for (int i = 0; i < 260; i++) send(32'd1, i == 259, 2'b10);
        expect_result(32'h00000104, 64'd255);

        auto_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            logic [1:0] s;
            len = $urandom_range(1, 8);
            s   = 2'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) cycle();
                send($urandom, i == len - 1, (i == 0) ? s : 2'($urandom_range(0, 3)));
            end
        end
        auto_ready = 1'b0;
        out_ready  = 1'b1;
        for (int n = 0; n < 10 && phase != 0; n++) cycle();
        check("drain", 64'(phase), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
